// File: rtl/aes_pkg.sv
// Shared AES constants, state encoding and word helpers for the key schedule
// and the SubBytes datapaths.
package aes_pkg;

  localparam int NR     = 10;
  localparam int KEY_W  = 128;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    STREAM
  } state_t;

  // Round constant for rounds 1..10; index 0 and beyond 10 never contribute.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Cyclic left rotate by one byte: {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
  function automatic logic [WORD_W-1:0] rot_word(input logic [WORD_W-1:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte wide, purely combinational lookup.
module aes_sbox (
  input  logic [7:0] value,
  output logic [7:0] result
);

  // Entry 0x00 sits in the top byte, entry 0xff in the bottom byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign result = SBOX[11'd2047 - {value, 3'b000} -: 8];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// AES-128 decryption round-key generator: expands the cipher key forward to
// round 10, then walks the schedule backwards emitting keys 10..0 over
// valid/ready. FIPS-197 byte 0 occupies bits [127:120] of every key bus.
module aes_inv_key_schedule
  import aes_pkg::*;
#(
  parameter int NR = aes_pkg::NR
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_load,
  output logic             busy,
  output logic [KEY_W-1:0] rk_out,
  output logic [3:0]       rk_round,
  output logic             rk_valid,
  input  logic             rk_ready
);

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t            state;
  logic [KEY_W-1:0]  key_reg;
  logic [3:0]        round;

  logic [WORD_W-1:0] w0, w1, w2, w3;
  logic [WORD_W-1:0] n0, n1, n2, n3;
  logic [WORD_W-1:0] p0, p1, p2, p3;
  logic [WORD_W-1:0] sub_in, sub_out, t_word;
  logic [3:0]        rcon_idx;

  assign {w0, w1, w2, w3} = key_reg;

  // One shared SubWord: EXPAND feeds w3, STREAM feeds the recovered p3.
  always_comb begin
    p3       = w3 ^ w2;
    p2       = w2 ^ w1;
    p1       = w1 ^ w0;
    sub_in   = (state == STREAM) ? rot_word(p3) : rot_word(w3);
    rcon_idx = (state == STREAM) ? round : round + 4'd1;
    t_word   = sub_out ^ {rcon(rcon_idx), 24'h000000};
    n0       = w0 ^ t_word;
    n1       = w1 ^ n0;
    n2       = w2 ^ n1;
    n3       = w3 ^ n2;
    p0       = w0 ^ t_word;
  end

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .value  (sub_in[8*i +: 8]),
      .result (sub_out[8*i +: 8])
    );
  end

  // Load, forward expansion and reverse streaming all live in one FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      key_reg  <= '0;
      round    <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_load) begin
            key_reg <= key_in;
            round   <= 4'd0;
            state   <= EXPAND;
            busy    <= 1'b1;
          end
        end
        EXPAND: begin
          key_reg <= {n0, n1, n2, n3};
          round   <= rcon_idx;
          if (rcon_idx == LAST_ROUND) begin
            state    <= STREAM;
            rk_valid <= 1'b1;
          end
        end
        STREAM: begin
          if (rk_valid && rk_ready) begin
            if (round != 4'd0) begin
              key_reg <= {p0, p1, p2, p3};
              round   <= round - 4'd1;
            end else begin
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rk_out   = key_reg;
  assign rk_round = round;

endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Round-key producer for the AES-128 inverse cipher: the decryption-side counterpart of the encryption round-key path.
- Accepts a 128-bit cipher key and expands it forward to the round-10 key, one round per cycle.
- Then streams round keys 10, 9, … 0 in reverse order over a valid/ready interface, using the inverse key recurrence.
- Output feeds the decryption round pipeline's key-addition stage directly.

Parameters:
- NR, 10, number of rounds (AES-128 only; other values unsupported).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- key_in  input  128  cipher key, [0:127] order, bit 0 = MSB of byte 0 (FIPS-197 order).
- key_load  input  1  single-cycle request; key_in sampled when key_load=1 and state is IDLE.
- busy  output  1  high from the edge after key_load is accepted until the round-0 key handshake completes.
- rk_out  output  128  current round key, [0:127] order, registered.
- rk_round  output  4  index of the round key on rk_out (10 down to 0).
- rk_valid  output  1  rk_out/rk_round hold a key to be consumed.
- rk_ready  input  1  consumer accepts the key when rk_valid & rk_ready at a rising edge.

Behaviour:
- Reset (reset=0, async): state=IDLE, key_reg=0, round=0, rk_out=0, rk_round=0, rk_valid=0, busy=0.
- IDLE:
  - key_load=1 → key_reg<=key_in, round<=0, state<=EXPAND, busy<=1.
  - key_load=0 → hold.
- EXPAND: each edge computes the next round key from key_reg, with words w0..w3 and r = round+1:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r],00,00,00}; n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2; round<=r.
  - When r = 10: state<=STREAM, rk_valid<=1.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Latency: rk_valid rises after the 10th rising edge following the load-sampling edge, with rk_round=10 and rk_out = round-10 key.
- STREAM: rk_out=key_reg and rk_round=round, driven from registers.
  - rk_valid=1 and rk_ready=0 → all outputs held stable (no change permitted).
  - Handshake with round>0 → key_reg <= previous key, round<=round-1, rk_valid stays 1. Previous key from current k0..k3 with r=round:
    - p3=k3^k2, p2=k2^k1, p1=k1^k0.
    - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],00,00,00}.
  - Handshake with round=0 → rk_valid<=0, busy<=0, state<=IDLE; key_reg keeps round-0 key.
- Throughput: one key per cycle with rk_ready held high; 11 keys in 11 consecutive cycles.
- key_load while busy=1 is ignored; no queuing, no effect on the stream.
- key_load in the same cycle as the final round-0 handshake is ignored (state is still STREAM).
- reset asserted mid-EXPAND or mid-STREAM: immediate return to reset values; no partial key is emitted afterwards.
- SubWord hardware: exactly one instance of four S-boxes, shared.
  - EXPAND feeds w3; STREAM feeds p3 (states are mutually exclusive).
  - Muxed input and rcon selection are combinational; no other combinational path to outputs.

Decomposition:
- Shared package aes_pkg holds:
  - Rcon table as a function/constant indexed 1..10.
  - NR and key/word width constants.
  - RotWord function.
  - State encoding IDLE/EXPAND/STREAM.
- Sub-module aes_sbox: 8-bit combinational forward S-box LUT, instantiated four times to form SubWord. It is reusable by the encryption SubBytes path.

Test Plan:
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → after 10 edges:
  - rk_round=10, rk_out=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Next cycle: rk_round=9, rk_out=ac7766f319fadc2128d12941575c006e.
  - rk_round=1: a0fafe1788542cb123a339392a6c7605.
  - rk_round=0: 2b7e…4f3c; then rk_valid=0, busy=0.
- All-zero key → rk_round=10 gives b4ef5bcb3e92e21123e951cf6f8f188e; rk_round=1 gives 62636363626363636263636362636363; rk_round=0 gives 0.
- Backpressure: same A.1 key, rk_ready toggled pseudo-randomly → rk_out/rk_round stable whenever valid&!ready; sequence of 11 accepted keys identical to the rk_ready=1 run.
- key_load pulsed with a different key during EXPAND and during STREAM → ignored; emitted keys match the first key only.
- reset=0 asserted while rk_round=5 → all outputs 0 asynchronously. After release, IDLE; a new key_load produces a full correct 10..0 sequence.
- Back-to-back: key_load asserted the cycle after the round-0 handshake → accepted. busy rises next edge; second key's round-10 appears 10 edges later.
